// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, defaults and state type for the SPI slave
package spi_pkg;
    localparam int SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'h00;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } spi_slv_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulses on the synchronized level
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev   <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev   <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;
endmodule

// File: rtl/axis_spi_slave.sv
// rtl/axis_spi_slave.sv - mode-0 SPI slave with byte streams, pins oversampled in the clk domain
module axis_spi_slave
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCK,
    input  logic                  SS_N,
    input  logic                  MOSI,
    output logic                  MISO_O,
    output logic                  MISO_T,
    input  logic [SPI_BYTE_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [SPI_BYTE_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  stat_busy,
    output logic                  stat_overrun,
    output logic                  stat_underrun,
    output logic                  stat_abort
);
    logic sck_level_unused, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .din(SCK),
        .dout(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(SS_N),
        .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(MOSI),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_slv_state_t        state;
    logic [SPI_BYTE_W-1:0] tx_sr, rx_sr, hold_data, rx_next;
    logic                  hold_valid, load_now;
    logic [2:0]            bit_cnt;

    assign rx_next       = {rx_sr[SPI_BYTE_W-2:0], mosi_s};
    assign s_axis_tready = ~hold_valid;
    assign stat_busy     = ~ss_s;

    // A byte boundary reached on the SCK fall that coincides with SS_N release never reloads.
    assign load_now = (state == ST_IDLE) ? ss_fall
                                         : (!ss_rise && sck_fall && bit_cnt == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            MISO_O        <= 1'b0;
            MISO_T        <= 1'b1;
            tx_sr         <= '0;
            rx_sr         <= '0;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            bit_cnt       <= 3'd0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            stat_overrun  <= 1'b0;
            stat_underrun <= 1'b0;
            stat_abort    <= 1'b0;
        end else begin
            stat_overrun  <= 1'b0;
            stat_underrun <= 1'b0;
            stat_abort    <= 1'b0;
            MISO_O        <= tx_sr[SPI_BYTE_W-1];

            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

            if (s_axis_tvalid && !hold_valid) begin
                hold_data  <= s_axis_tdata;
                hold_valid <= 1'b1;
            end

            if (load_now) begin
                if (hold_valid) begin
                    tx_sr      <= hold_data;
                    hold_valid <= 1'b0;
                end else begin
                    tx_sr         <= IDLE_BYTE;
                    stat_underrun <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state   <= ST_ACTIVE;
                        MISO_T  <= 1'b0;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise) begin
                        state   <= ST_IDLE;
                        MISO_T  <= 1'b1;
                        bit_cnt <= 3'd0;
                        rx_sr   <= '0;
                        if (bit_cnt != 3'd0) stat_abort <= 1'b1;
                    end else if (sck_rise) begin
                        rx_sr   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (m_axis_tvalid && !m_axis_tready) begin
                                stat_overrun <= 1'b1;
                            end else begin
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= rx_next;
                            end
                        end
                    end else if (sck_fall && bit_cnt != 3'd0) begin
                        tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_spi_slave.sv
// tb/tb_axis_spi_slave.sv - bench for axis_spi_slave: directed frame table, reset sequence, random frames
module tb_axis_spi_slave;
    localparam int HALF = 8;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       rst, SCK, SS_N, MOSI;
    logic       MISO_O, MISO_T;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       stat_busy, stat_overrun, stat_underrun, stat_abort;

    always #5 clk = ~clk;

    axis_spi_slave #(.IDLE_BYTE(IDLE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .SS_N(SS_N), .MOSI(MOSI),
        .MISO_O(MISO_O), .MISO_T(MISO_T),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .stat_busy(stat_busy), .stat_overrun(stat_overrun),
        .stat_underrun(stat_underrun), .stat_abort(stat_abort)
    );

    typedef struct {
        int          nbits;
        logic [31:0] mosi;
        logic [31:0] tx;
        logic [3:0]  sup;
        logic        early;
        int          rdy;
        logic [31:0] e_miso;
        int          e_under;
        int          e_over;
        int          e_abort;
        int          e_rx_n;
        logic [31:0] e_rx;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int n_under = 0, n_over = 0, n_abort = 0;
    int rdy_mode = 1;
    logic [7:0] got_q[$];
    vec_t vecs[8];

    always @(negedge clk) begin
        if (rdy_mode == 0) m_axis_tready = 1'b0;
        else if (rdy_mode == 1) m_axis_tready = 1'b1;
        else m_axis_tready = 1'($urandom_range(0, 1));
        if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
        if (stat_underrun) n_under++;
        if (stat_overrun) n_over++;
        if (stat_abort) n_abort++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    // SCK released low together with SS_N on the final bit, so no trailing reload happens.
    task automatic run_frame(input int nbits, input logic [31:0] mosi, input logic [31:0] tx,
                             input logic [3:0] sup, input logic early,
                             output logic [31:0] miso, output logic t_act, output logic busy_act);
        int loads;
        loads    = 1 + (nbits - 1) / 8;
        miso     = '0;
        t_act    = 1'b1;
        busy_act = 1'b0;
        if (sup[3]) push_tx(tx[31:24]);
        SS_N = 1'b0;
        MOSI = mosi[31];
        if (early) begin
            repeat (2) @(negedge clk);
            push_tx(tx[31:24]);
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        for (int b = 0; b < nbits; b++) begin
            int k;
            k = b / 8;
            SCK = 1'b1;
            miso[31-b] = MISO_O;
            if (b == 0) begin
                t_act    = MISO_T;
                busy_act = stat_busy;
            end
            if (b % 8 == 3 && k + 1 < loads && sup[2-k]) push_tx(tx[23-8*k -: 8]);
            else @(negedge clk);
            repeat (HALF - 1) @(negedge clk);
            SCK = 1'b0;
            if (b == nbits - 1) SS_N = 1'b1;
            else MOSI = mosi[30-b];
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [31:0] miso, rxw, mask;
        logic        t_act, busy_act;
        int          nfull;
        n_under = 0;
        n_over  = 0;
        n_abort = 0;
        got_q.delete();
        rdy_mode = v.rdy;
        run_frame(v.nbits, v.mosi, v.tx, v.sup, v.early, miso, t_act, busy_act);
        if (v.rdy == 0) check({tag, "_held_tdata"}, 32'(m_axis_tdata), 32'(v.e_rx[31:24]));
        rdy_mode = 1;
        repeat (20) @(negedge clk);
        nfull = v.nbits / 8;
        mask  = ~(32'hFFFF_FFFF >> (8 * nfull));
        rxw   = '0;
        for (int i = 0; i < got_q.size() && i < 4; i++) rxw[31-8*i -: 8] = got_q[i];
        if (nfull > 0) check({tag, "_miso"}, miso & mask, v.e_miso & mask);
        check({tag, "_miso_t_active"}, 32'(t_act), 32'd0);
        check({tag, "_busy_active"}, 32'(busy_act), 32'd1);
        check({tag, "_miso_t_idle"}, 32'(MISO_T), 32'd1);
        check({tag, "_underruns"}, n_under, v.e_under);
        check({tag, "_overruns"}, n_over, v.e_over);
        check({tag, "_aborts"}, n_abort, v.e_abort);
        check({tag, "_rx_count"}, got_q.size(), v.e_rx_n);
        check({tag, "_rx_data"}, rxw, v.e_rx);
    endtask

    initial begin
        vecs[0] = '{8,  32'h3C000000, 32'hA5000000, 4'b1000, 1'b0, 1, 32'hA5000000, 0, 0, 0, 1, 32'h3C000000};
        vecs[1] = '{16, 32'h12340000, 32'h00000000, 4'b0000, 1'b0, 1, 32'h00000000, 2, 0, 0, 2, 32'h12340000};
        vecs[2] = '{24, 32'h01020300, 32'h00000000, 4'b0000, 1'b0, 0, 32'h00000000, 3, 2, 0, 1, 32'h01000000};
        vecs[3] = '{5,  32'hA8000000, 32'h00000000, 4'b0000, 1'b0, 1, 32'h00000000, 1, 0, 1, 0, 32'h00000000};
        vecs[4] = '{8,  32'hFF000000, 32'h00000000, 4'b0000, 1'b0, 1, 32'h00000000, 1, 0, 0, 1, 32'hFF000000};
        vecs[5] = '{32, 32'h5AC3E718, 32'hDEADBEEF, 4'b1111, 1'b0, 1, 32'hDEADBEEF, 0, 0, 0, 4, 32'h5AC3E718};
        vecs[6] = '{16, 32'h0F0F0000, 32'h66000000, 4'b0000, 1'b1, 1, 32'h00660000, 1, 0, 0, 2, 32'h0F0F0000};
        vecs[7] = '{8,  32'h99000000, 32'h00000000, 4'b0000, 1'b0, 1, 32'h00000000, 1, 0, 0, 1, 32'h99000000};

        rst = 1'b1; SCK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_miso_o", 32'(MISO_O), 32'd0);
        check("reset_miso_t", 32'(MISO_T), 32'd1);
        check("reset_s_tready", 32'(s_axis_tready), 32'd1);
        check("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset_m_tdata", 32'(m_axis_tdata), 32'd0);
        check("reset_stats", 32'({stat_busy, stat_overrun, stat_underrun, stat_abort}), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-byte while the holding register is full.
        push_tx(8'h77);
        SS_N = 1'b0; MOSI = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            SCK = 1'b1; repeat (HALF) @(negedge clk);
            SCK = 1'b0; repeat (HALF) @(negedge clk);
        end
        push_tx(8'h88);
        check("midrst_hold_full", 32'(s_axis_tready), 32'd0);
        rst = 1'b1; SS_N = 1'b1;
        @(negedge clk);
        check("midrst_miso_o", 32'(MISO_O), 32'd0);
        check("midrst_miso_t", 32'(MISO_T), 32'd1);
        check("midrst_s_tready", 32'(s_axis_tready), 32'd1);
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_stats", 32'({stat_busy, stat_overrun, stat_underrun, stat_abort}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        apply(vecs[7], "post_rst");

        for (int r = 0; r < 24; r++) begin
            vec_t v;
            int   loads;
            v.nbits = ($urandom_range(0, 1) == 1) ? 8 * int'($urandom_range(1, 4)) : int'($urandom_range(1, 32));
            v.mosi  = $urandom;
            v.tx    = $urandom;
            v.sup   = 4'($urandom);
            v.early = 1'b0;
            v.rdy   = 2;
            loads   = 1 + (v.nbits - 1) / 8;
            v.e_miso  = '0;
            v.e_under = 0;
            for (int k = 0; k < loads; k++) begin
                if (v.sup[3-k]) v.e_miso[31-8*k -: 8] = v.tx[31-8*k -: 8];
                else begin
                    v.e_miso[31-8*k -: 8] = IDLE;
                    v.e_under++;
                end
            end
            v.e_over  = 0;
            v.e_abort = (v.nbits % 8 != 0) ? 1 : 0;
            v.e_rx_n  = v.nbits / 8;
            v.e_rx    = v.mosi & ~(32'hFFFF_FFFF >> (8 * (v.nbits / 8)));
            apply(v, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
